// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Brief    : Shared state encoding and select bit-order helper for digit scan.
// Revision : 1.0
// ============================================================================
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } scan_state_t;

    localparam int c_NUM_DIGITS = 4;

    // With swap set, decoder line D[k] fires for digit k; the segment mux
    // must apply the same ordering.
    function automatic logic [1:0] sel_order(input logic [1:0] idx, input logic swap);
        return swap ? {idx[0], idx[1]} : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_digit_pick.sv
`default_nettype none
// ============================================================================
// Module   : next_digit_pick
// Brief    : 4-bit circular priority picker: next set mask bit after idx.
// Revision : 1.0
// ============================================================================
module next_digit_pick (
    input  logic [3:0] mask,
    input  logic [1:0] idx,
    output logic [1:0] next_idx,
    output logic       wrap,
    output logic       found
);

    logic [1:0] w_cand;

    // Scan distances 4 down to 1 so the nearest set bit is written last;
    // distance 4 is idx itself, covering the single-digit case.
    always_comb begin
        next_idx = idx;
        found    = 1'b0;
        w_cand   = idx;
        for (int k = 4; k >= 1; k--) begin
            w_cand = idx + k[1:0];
            if (mask[w_cand]) begin
                next_idx = w_cand;
                found    = 1'b1;
            end
        end
        wrap = found && (next_idx <= idx);
    end

endmodule
`default_nettype wire

// File: rtl/digit_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_sequencer
// Brief    : Round-robin 4-digit scan with per-slot blanking for a 2:4 decoder.
// Revision : 1.0
// ============================================================================
module digit_scan_sequencer
    import scan_pkg::*;
#(
    parameter int TICK_DIV = 8,
    parameter int BLANK    = 2,
    parameter bit SEL_SWAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       en,
    output logic [1:0] digit,
    output logic       frame_done
);

    localparam logic [15:0] c_TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [15:0] c_BLANK_LAST = 16'(BLANK - 1);

    scan_state_t r_state;
    scan_state_t w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_nxt;
    logic        w_fd_nxt;
    logic        r_en;
    logic [1:0]  r_sel;
    logic        r_fd;

    logic [1:0]  w_pick_from;
    logic [1:0]  w_pick_idx;
    logic        w_pick_wrap;
    logic        w_pick_found;

    // Searching from index 3 yields the lowest set bit, so one picker serves
    // both the start-of-scan and the end-of-slot cases.
    assign w_pick_from = (r_state == ST_IDLE) ? 2'd3 : r_idx;

    next_digit_pick u_pick (
        .mask     (mask),
        .idx      (w_pick_from),
        .next_idx (w_pick_idx),
        .wrap     (w_pick_wrap),
        .found    (w_pick_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_fd_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 16'd0;
                if (run && w_pick_found) begin
                    w_state_nxt = ST_BLANK;
                    w_idx_nxt   = w_pick_idx;
                end
            end
            ST_BLANK: begin
                if (!run) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (!run) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_TICK_LAST) begin
                    w_cnt_nxt = 16'd0;
                    if (w_pick_found) begin
                        w_state_nxt = ST_BLANK;
                        w_idx_nxt   = w_pick_idx;
                        w_fd_nxt    = w_pick_wrap;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // state they describe without any input-to-output path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_idx   <= 2'd0;
            r_en    <= 1'b0;
            r_sel   <= 2'd0;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_en    <= (w_state_nxt == ST_ON);
            r_sel   <= sel_order(w_idx_nxt, SEL_SWAP);
            r_fd    <= w_fd_nxt;
        end
    end

    assign sel        = r_sel;
    assign en         = r_en;
    assign digit      = r_idx;
    assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_scan_sequencer
// Brief    : Directed and randomized checks against a slot-age reference model.
// Revision : 1.0
// ============================================================================
module tb_digit_scan_sequencer;

    localparam int TICK_DIV = 8;
    localparam int BLANK    = 2;
    localparam bit SEL_SWAP = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] mask = 4'h0;
    logic [1:0] sel;
    logic       en;
    logic [1:0] digit;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: is a digit being shown, how old is its slot, which digit.
    bit m_active = 1'b0;
    int m_age    = 0;
    int m_idx    = 0;
    bit m_fd     = 1'b0;

    digit_scan_sequencer #(
        .TICK_DIV (TICK_DIV),
        .BLANK    (BLANK),
        .SEL_SWAP (SEL_SWAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mask       (mask),
        .sel        (sel),
        .en         (en),
        .digit      (digit),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    function automatic int lowest_set(input logic [3:0] mk);
        for (int k = 0; k < 4; k++) if (mk[k]) return k;
        return 0;
    endfunction

    function automatic int next_set(input logic [3:0] mk, input int from);
        for (int k = 1; k <= 4; k++) if (mk[(from + k) % 4]) return (from + k) % 4;
        return from;
    endfunction

    task automatic model_step();
        int n;
        if (!rst_n) begin
            m_active = 1'b0; m_age = 0; m_idx = 0; m_fd = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (!m_active) begin
                if (run && mask != 4'h0) begin
                    m_active = 1'b1; m_age = 0; m_idx = lowest_set(mask);
                end
            end else if (!run) begin
                m_active = 1'b0;
            end else if (m_age == TICK_DIV - 1) begin
                if (mask == 4'h0) begin
                    m_active = 1'b0;
                end else begin
                    n = next_set(mask, m_idx);
                    m_fd  = (n <= m_idx);
                    m_idx = n;
                    m_age = 0;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic logic [5:0] expected();
        logic [1:0] i2;
        logic [1:0] s;
        i2 = m_idx[1:0];
        s  = SEL_SWAP ? {i2[0], i2[1]} : i2;
        return {s, (m_active && m_age >= BLANK), i2, m_fd};
    endfunction

    function automatic logic [5:0] observed();
        return {sel, en, digit, frame_done};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] en_seq;
        rst_n = 1'b0; run = 1'b1; mask = 4'hF;
        tick(); tick();
        n_checks++;
        if (observed() !== 6'b0) begin
            n_fail++; $display("FAIL reset_values: got %b want %b", observed(), 6'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            en_seq[2 - i] = en;
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL reset_release_model: got %b want %b", observed(), expected());
            end
        end
        n_checks++;
        if (en_seq !== 3'b001) begin
            n_fail++; $display("FAIL reset_first_en: got %b want %b", en_seq, 3'b001);
        end
    endtask

    task automatic test_full_scan();
        int pulses = 0;
        int en_cnt = 0;
        logic [1:0] prev;
        mask = 4'hF; run = 1'b1;
        prev = digit;
        for (int i = 0; i < 64; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL full_scan_model: got %b want %b", observed(), expected());
            end
            if (en) en_cnt++;
            if (digit != prev) begin
                n_checks++;
                if (digit !== prev + 2'd1) begin
                    n_fail++; $display("FAIL full_scan_order: got %0d want %0d", digit, prev + 2'd1);
                end
            end
            prev = digit;
            if (frame_done) begin
                pulses++;
                n_checks++;
                if (digit !== 2'd0) begin
                    n_fail++; $display("FAIL full_scan_fd_digit: got %0d want 0", digit);
                end
            end
            if (digit == 2'd1) begin
                n_checks++;
                if (sel !== 2'b10) begin
                    n_fail++; $display("FAIL sel_swap_d1: got %b want 10", sel);
                end
            end
            if (digit == 2'd2) begin
                n_checks++;
                if (sel !== 2'b01) begin
                    n_fail++; $display("FAIL sel_swap_d2: got %b want 01", sel);
                end
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL full_scan_pulses: got %0d want 2", pulses);
        end
        n_checks++;
        if (en_cnt != 48) begin
            n_fail++; $display("FAIL full_scan_en_cycles: got %0d want 48", en_cnt);
        end
    endtask

    task automatic test_mask_1010();
        int pulses = 0;
        mask = 4'b1010; run = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL mask1010_model: got %b want %b", observed(), expected());
            end
            if (i >= 16) begin
                n_checks++;
                if (digit !== 2'd1 && digit !== 2'd3) begin
                    n_fail++; $display("FAIL mask1010_digit: got %0d want 1 or 3", digit);
                end
                if (frame_done) begin
                    pulses++;
                    n_checks++;
                    if (digit !== 2'd1) begin
                        n_fail++; $display("FAIL mask1010_fd_digit: got %0d want 1", digit);
                    end
                end
            end
        end
        n_checks++;
        if (pulses != 4) begin
            n_fail++; $display("FAIL mask1010_pulses: got %0d want 4", pulses);
        end
    endtask

    task automatic test_single_digit();
        int pulses = 0;
        int en_cnt = 0;
        mask = 4'b0100; run = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL single_model: got %b want %b", observed(), expected());
            end
            if (i >= 16) begin
                if (frame_done) pulses++;
                if (en) en_cnt++;
                n_checks++;
                if (digit !== 2'd2) begin
                    n_fail++; $display("FAIL single_digit: got %0d want 2", digit);
                end
            end
        end
        n_checks++;
        if (pulses != 8 || en_cnt != 48) begin
            n_fail++; $display("FAIL single_rate: got pulses=%0d en=%0d want 8/48", pulses, en_cnt);
        end
    endtask

    task automatic test_run_drop();
        bit found = 1'b0;
        logic [2:0] en_seq;
        mask = 4'hF; run = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL run_drop_model: got %b want %b", observed(), expected());
            end
            if (digit == 2'd2 && en) found = 1'b1;
        end
        if (!found) begin
            n_checks++; n_fail++; $display("FAIL run_drop_wait: got timeout want digit 2 on");
        end
        tick(); tick(); tick();
        run = 1'b0;
        tick();
        n_checks++;
        if (en !== 1'b0 || observed() !== expected()) begin
            n_fail++; $display("FAIL run_drop_en: got %b want %b", observed(), expected());
        end
        tick(); tick();
        mask = 4'b1100; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            en_seq[2 - i] = en;
            n_checks++;
            if (digit !== 2'd2 || observed() !== expected()) begin
                n_fail++; $display("FAIL run_restart: got %b want %b", observed(), expected());
            end
        end
        n_checks++;
        if (en_seq !== 3'b001) begin
            n_fail++; $display("FAIL run_restart_blank: got %b want 001", en_seq);
        end
    endtask

    task automatic test_mid_mask_change();
        bit found = 1'b0;
        bit moved = 1'b0;
        mask = 4'hF; run = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (digit == 2'd1 && en) found = 1'b1;
        end
        n_checks++;
        if (!found || observed() !== expected()) begin
            n_fail++; $display("FAIL mid_mask_wait: got found=%0d %b want %b", found, observed(), expected());
        end
        mask = 4'b0001;
        for (int i = 0; i < 20 && !moved; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL mid_mask_model: got %b want %b", observed(), expected());
            end
            if (digit != 2'd1) moved = 1'b1;
        end
        n_checks++;
        if (!moved || digit !== 2'd0 || frame_done !== 1'b1 || en !== 1'b0) begin
            n_fail++; $display("FAIL mid_mask_wrap: got d=%0d fd=%b en=%b want d=0 fd=1 en=0", digit, frame_done, en);
        end
    endtask

    task automatic test_mask_zero();
        bit found = 1'b0;
        logic [1:0] held;
        mask = 4'hF; run = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (en) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL mask_zero_wait: got timeout want en high");
        end
        held = digit;
        mask = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL mask_zero_model: got %b want %b", observed(), expected());
            end
        end
        n_checks++;
        if (en !== 1'b0 || digit !== held || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL mask_zero_idle: got en=%b d=%0d want en=0 d=%0d", en, digit, held);
        end
    endtask

    task automatic test_reset_mid_on();
        bit found = 1'b0;
        mask = 4'hF; run = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (en && digit != 2'd0) found = 1'b1;
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (!found || observed() !== 6'b0) begin
            n_fail++; $display("FAIL reset_mid_on: got found=%0d %b want 000000", found, observed());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if (run && $urandom_range(0, 199) == 0) run = 1'b0;
            else if (!run && $urandom_range(0, 9) == 0) run = 1'b1;
            if ($urandom_range(0, 59) == 0) mask = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL random_model: cycle %0d got %b want %b", i, observed(), expected());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_mask_1010();
        test_single_digit();
        test_run_drop();
        test_mid_mask_change();
        test_mask_zero();
        test_reset_mid_on();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_scan_sequencer.md
# digit_scan_sequencer

- Sequential front end for `TwoFourDecoder` in 4-digit display multiplexing.
- Walks round-robin over the digits enabled in a mask and holds each one for a fixed slot.
- At the start of each slot, inserts a blanking interval with the enable low to suppress ghosting.
- Drives the decoder's select pair and enable directly; `D[3:0]` then becomes the active-digit strobe.

## Interface
- `TICK_DIV`, 8: slot length in clock cycles. Legal range 2..65535.
- `BLANK`, 2: cycles at the start of each slot with `en`=0. Legal range 1..`TICK_DIV`-1.
- `SEL_SWAP`, 1: 1 drives `sel` = {idx[0], idx[1]}, so decoder line `D[k]` fires for digit k; 0 drives `sel` = idx.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `run`  in  1  scan enable; level-sensitive.
- `mask`  in  4  per-digit enable; bit k=1 means digit k takes part in the scan.
- `sel`  out  2  decoder select (`I`), bit order set by `SEL_SWAP`.
- `en`  out  1  decoder enable (`E`).
- `digit`  out  2  current digit index idx, always unswapped (for the segment-data mux).
- `frame_done`  out  1  one-cycle pulse when the scan wraps back to a lower-or-equal index.

## Operation
- State machine: IDLE, BLANK, ON. Slot counter `cnt` is 16 bits and counts 0..`TICK_DIV`-1 within a slot.
- Reset (`rst_n`=0 at an edge, in any state): state=IDLE, `cnt`=0, idx=0, `sel`=0, `en`=0, `digit`=0, `frame_done`=0.
- IDLE: `en`=0, `cnt` held at 0.
  - If `run`=1 and `mask`≠0: idx ← lowest set bit of `mask`, then go to BLANK.
  - Otherwise stay in IDLE.
- BLANK: `en`=0 and `cnt` increments. When `cnt`=`BLANK`-1, go to ON.
- ON: `en`=1 and `cnt` increments. When `cnt`=`TICK_DIV`-1:
  - `cnt` ← 0.
  - idx ← next set bit of `mask` searching circularly from idx+1.
  - Go to BLANK.
  - If the new idx ≤ the old idx, assert `frame_done` for exactly that one cycle.
- `mask` change mid-slot: the current slot runs to completion even if its digit is now masked. The new `mask` takes effect at slot end.
- `mask`=0 at slot end: go to IDLE, `en`=0, idx unchanged, no `frame_done`.
- Single enabled digit: idx stays put and `frame_done` pulses at every slot end.
- `run`=0 sampled in BLANK or ON: go to IDLE at that edge, so `en`=0 the next cycle; no `frame_done`. Re-asserting `run` restarts from the lowest set bit with a full blanking interval.
- `run`=0 and slot end on the same edge: `run` wins; go to IDLE with idx unchanged.
- `sel` and `digit` always track idx, including in IDLE.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- `run` sampled high in IDLE at edge E0: BLANK from E0. `en` rises after edge E0+`BLANK` and stays high for `TICK_DIV`-`BLANK` cycles.
- Period per enabled digit is exactly `TICK_DIV` cycles. A frame lasts popcount(`mask`)·`TICK_DIV` cycles.
- `sel`/`digit` change only on the edge that enters BLANK, never while `en`=1.
- `frame_done` is coincident with the first BLANK cycle of the new frame.

## Structure
- Shared package/header `scan_pkg`:
  - state encodings IDLE=2'd0, BLANK=2'd1, ON=2'd2 (2'd3 recovers to IDLE);
  - the `SEL_SWAP` bit-order convention, reused by the segment mux.
- One sub-module: `next_digit_pick`.
  - Purely combinational 4-bit circular priority picker.
  - Inputs (`mask`, idx); outputs next idx and a wrap flag.
  - Verified standalone, exhaustively over all 64 input combinations.
- Top level holds the FSM, `cnt` and the output registers.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `run`=1 and `mask`=4'hF -> `sel`=0, `en`=0, `digit`=0, `frame_done`=0. Release -> first `en` high 2 cycles later.
- `mask`=4'b1111 and `run`=1 with default parameters:
  - `digit` runs 0,1,2,3,0; each slot is 8 cycles, `en` pattern 0,0,1,1,1,1,1,1;
  - `frame_done` pulses once per 32 cycles, on the 3→0 transition;
  - with `SEL_SWAP`=1, digit 1 gives `sel`=2'b10 and digit 2 gives `sel`=2'b01.
- `mask`=4'b1010: `digit` sequence 1,3,1,3; `frame_done` on each 3→1; frame length 16 cycles.
- `mask`=4'b0100: `digit` stays at 2 with blanking every slot; `frame_done` every 8 cycles.
- Drop `run` at `cnt`=5 of digit 2 -> `en`=0 next cycle, state IDLE. Re-raise `run` with `mask`=4'b1100 -> restart at digit 2 with 2 blank cycles.
- Mid-slot events:
  - change `mask` from 4'b1111 to 4'b0001 during digit 1 -> digit 1 slot completes, then digit 0, with `frame_done` on 1→0;
  - set `mask`=0 mid-slot -> IDLE at slot end;
  - assert `rst_n`=0 mid-ON -> all outputs at reset values the next cycle.
